// File: rtl/exc_sequencer_pkg.sv
// Shared cause codes and FSM state encoding for the precise exception sequencer.
package exc_sequencer_pkg;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_INTR    = 3'd1;
  localparam logic [2:0] CAUSE_DECERR  = 3'd2;
  localparam logic [2:0] CAUSE_SYSCALL = 3'd3;
  localparam logic [2:0] CAUSE_BREAK   = 3'd4;
  localparam logic [2:0] CAUSE_OVF     = 3'd5;
  localparam logic [2:0] CAUSE_BUSERR  = 3'd6;

  // ENTER is not a register state: it is the combinational trigger cycle in IDLE.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } exc_state_e;

  function automatic logic [31:0] ivt_page(input logic [21:0] ivtbase);
    return {ivtbase, 10'b0};
  endfunction

endpackage

// File: rtl/exc_sequencer_prio.sv
// Priority encoder: an already-known older cause passes through, otherwise the
// highest of three request lines selects its code.
module exc_prio_enc
  import exc_sequencer_pkg::*;
#(
  parameter logic [2:0] CODE_HI  = CAUSE_NONE,
  parameter logic [2:0] CODE_MID = CAUSE_NONE,
  parameter logic [2:0] CODE_LO  = CAUSE_NONE
) (
  input  logic [2:0] i_pass,
  input  logic       i_req_hi,
  input  logic       i_req_mid,
  input  logic       i_req_lo,
  output logic [2:0] o_cause
);

  always_comb begin
    o_cause = CAUSE_NONE;
    if (i_pass != CAUSE_NONE) begin
      o_cause = i_pass;
    end else if (i_req_hi) begin
      o_cause = CODE_HI;
    end else if (i_req_mid) begin
      o_cause = CODE_MID;
    end else if (i_req_lo) begin
      o_cause = CODE_LO;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Precise exception/interrupt sequencer: carries causes down the pipe, enters COP0
// at the memory stage, then redirects fetch. Define CPU_EXC_VECTORED_EN for per-cause vectors.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter int VEC_SHIFT = 7
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_exec_stall,
  input  logic        i_mem_stall,
  input  logic        i_fetch_stall,
  input  logic [21:0] i_cop0_ivtbase,
  input  logic        i_cop0_ie,
  input  logic        i_intr,
  input  logic        i_dec_err_p1,
  input  logic        i_syscall_p1,
  input  logic        i_break_p1,
  input  logic        i_ovf_p2,
  input  logic        i_bus_err_p3,
  input  logic        i_valid_p3,
  input  logic        i_bdslot_p3,
  input  logic [31:0] i_pc_p3,
  output logic        o_except_start,
  output logic        o_except_dly_slt,
  output logic [31:0] o_except_raddr,
  output logic [31:0] o_except_raddr_dly,
  output logic        o_nullify_decode,
  output logic        o_nullify_execute,
  output logic        o_nullify_mem,
  output logic        o_nullify_wb,
  output logic        o_fetch_redirect,
  output logic [31:0] o_fetch_addr,
  output logic [2:0]  o_except_cause
);

  exc_state_e state_q, state_d;
  logic [2:0] cause_p2_q, cause_p2_d;
  logic [2:0] cause_p3_q, cause_p3_d;
  logic [2:0] last_cause_q, last_cause_d;
  logic [2:0] p1_cause, p2_cause, eff_cause;
  logic [31:0] vec_off;
  logic core_stall, intr_ok, trigger;

  assign core_stall = i_exec_stall | i_mem_stall | i_fetch_stall;
  assign intr_ok    = i_intr & i_cop0_ie & i_valid_p3;

  exc_prio_enc #(
    .CODE_HI (CAUSE_DECERR),
    .CODE_MID(CAUSE_SYSCALL),
    .CODE_LO (CAUSE_BREAK)
  ) u_prio_p1 (
    .i_pass   (CAUSE_NONE),
    .i_req_hi (i_dec_err_p1),
    .i_req_mid(i_syscall_p1),
    .i_req_lo (i_break_p1),
    .o_cause  (p1_cause)
  );

  exc_prio_enc #(
    .CODE_HI(CAUSE_OVF)
  ) u_prio_p2 (
    .i_pass   (cause_p2_q),
    .i_req_hi (i_ovf_p2),
    .i_req_mid(1'b0),
    .i_req_lo (1'b0),
    .o_cause  (p2_cause)
  );

  exc_prio_enc #(
    .CODE_HI (CAUSE_BUSERR),
    .CODE_MID(CAUSE_INTR)
  ) u_prio_p3 (
    .i_pass   (cause_p3_q),
    .i_req_hi (i_bus_err_p3),
    .i_req_mid(intr_ok),
    .i_req_lo (1'b0),
    .o_cause  (eff_cause)
  );

  assign trigger = (state_q == ST_IDLE) && (eff_cause != CAUSE_NONE) && !core_stall;

`ifdef CPU_EXC_VECTORED_EN
  assign vec_off = 32'(last_cause_q) << VEC_SHIFT;
`else
  assign vec_off = 32'(CAUSE_NONE) << VEC_SHIFT;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      cause_p2_q   <= CAUSE_NONE;
      cause_p3_q   <= CAUSE_NONE;
      last_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      cause_p2_q   <= cause_p2_d;
      cause_p3_q   <= cause_p3_d;
      last_cause_q <= last_cause_d;
    end
  end

  // Younger stages are being flushed in REDIR, so their sources never enter the pipe.
  always_comb begin
    state_d      = state_q;
    cause_p2_d   = cause_p2_q;
    cause_p3_d   = cause_p3_q;
    last_cause_d = last_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d      = ST_REDIR;
          cause_p2_d   = CAUSE_NONE;
          cause_p3_d   = CAUSE_NONE;
          last_cause_d = eff_cause;
        end else if (!core_stall) begin
          cause_p2_d = p1_cause;
          cause_p3_d = p2_cause;
        end
      end
      ST_REDIR: begin
        cause_p2_d = CAUSE_NONE;
        cause_p3_d = CAUSE_NONE;
        if (!core_stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated by nrst so a combinational trigger cannot leak out while in reset.
  always_comb begin
    o_except_start     = 1'b0;
    o_except_dly_slt   = 1'b0;
    o_except_raddr     = 32'd0;
    o_except_raddr_dly = 32'd0;
    o_nullify_decode   = 1'b0;
    o_nullify_execute  = 1'b0;
    o_nullify_mem      = 1'b0;
    o_nullify_wb       = 1'b0;
    o_fetch_redirect   = 1'b0;
    o_fetch_addr       = 32'd0;
    o_except_cause     = last_cause_q;
    if (nrst) begin
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            o_except_start     = 1'b1;
            o_except_dly_slt   = i_bdslot_p3;
            o_except_raddr     = i_pc_p3;
            o_except_raddr_dly = i_pc_p3 - 32'd4;
            o_nullify_decode   = 1'b1;
            o_nullify_execute  = 1'b1;
            o_nullify_mem      = 1'b1;
            o_nullify_wb       = 1'b1;
            o_except_cause     = eff_cause;
          end
        end
        ST_REDIR: begin
          o_fetch_redirect = 1'b1;
          o_nullify_decode = 1'b1;
          o_fetch_addr     = ivt_page(i_cop0_ivtbase) + vec_off;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios plus randomized traffic
// against a per-instruction cause model. Honours CPU_EXC_VECTORED_EN like the design.
module tb_exc_sequencer;

  logic        clk;
  logic        nrst;
  logic        i_exec_stall, i_mem_stall, i_fetch_stall;
  logic [21:0] i_cop0_ivtbase;
  logic        i_cop0_ie, i_intr;
  logic        i_dec_err_p1, i_syscall_p1, i_break_p1;
  logic        i_ovf_p2, i_bus_err_p3, i_valid_p3, i_bdslot_p3;
  logic [31:0] i_pc_p3;
  logic        o_except_start, o_except_dly_slt;
  logic [31:0] o_except_raddr, o_except_raddr_dly;
  logic        o_nullify_decode, o_nullify_execute, o_nullify_mem, o_nullify_wb;
  logic        o_fetch_redirect;
  logic [31:0] o_fetch_addr;
  logic [2:0]  o_except_cause;

  int total = 0;
  int bad   = 0;

  // Model: cause carried by the instruction in execute / memory, redirect pending, last cause.
  int m_cause_ex  = 0;
  int m_cause_mem = 0;
  bit m_redirect  = 0;
  int m_last      = 0;

  // DUT outputs captured at the most recent checked negedge.
  logic        s_start, s_dly, s_redirect, s_null_wb;
  logic [31:0] s_raddr, s_raddr_dly, s_fetch;
  logic [2:0]  s_cause;

  exc_sequencer dut (
    .clk               (clk),
    .nrst              (nrst),
    .i_exec_stall      (i_exec_stall),
    .i_mem_stall       (i_mem_stall),
    .i_fetch_stall     (i_fetch_stall),
    .i_cop0_ivtbase    (i_cop0_ivtbase),
    .i_cop0_ie         (i_cop0_ie),
    .i_intr            (i_intr),
    .i_dec_err_p1      (i_dec_err_p1),
    .i_syscall_p1      (i_syscall_p1),
    .i_break_p1        (i_break_p1),
    .i_ovf_p2          (i_ovf_p2),
    .i_bus_err_p3      (i_bus_err_p3),
    .i_valid_p3        (i_valid_p3),
    .i_bdslot_p3       (i_bdslot_p3),
    .i_pc_p3           (i_pc_p3),
    .o_except_start    (o_except_start),
    .o_except_dly_slt  (o_except_dly_slt),
    .o_except_raddr    (o_except_raddr),
    .o_except_raddr_dly(o_except_raddr_dly),
    .o_nullify_decode  (o_nullify_decode),
    .o_nullify_execute (o_nullify_execute),
    .o_nullify_mem     (o_nullify_mem),
    .o_nullify_wb      (o_nullify_wb),
    .o_fetch_redirect  (o_fetch_redirect),
    .o_fetch_addr      (o_fetch_addr),
    .o_except_cause    (o_except_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int vector_offset(input int cause);
`ifdef CPU_EXC_VECTORED_EN
    return cause * 128;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_exec_stall = 0; i_mem_stall = 0; i_fetch_stall = 0;
    i_cop0_ie = 1; i_intr = 0;
    i_dec_err_p1 = 0; i_syscall_p1 = 0; i_break_p1 = 0;
    i_ovf_p2 = 0; i_bus_err_p3 = 0;
    i_valid_p3 = 1; i_bdslot_p3 = 0; i_pc_p3 = 32'h0;
  endtask

  // Computes what every output must be this cycle from the model, compares, then advances the model.
  task automatic checkOutput();
    bit stall;
    int eff, p1;
    logic        e_start, e_dly, e_nd, e_nx, e_nm, e_nw, e_redir;
    logic [31:0] e_raddr, e_raddr_dly, e_fetch;
    logic [2:0]  e_cause;
    stall = i_exec_stall || i_mem_stall || i_fetch_stall;
    e_start = 0; e_dly = 0; e_nd = 0; e_nx = 0; e_nm = 0; e_nw = 0; e_redir = 0;
    e_raddr = 0; e_raddr_dly = 0; e_fetch = 0;
    if (!nrst) begin
      m_cause_ex = 0; m_cause_mem = 0; m_redirect = 0; m_last = 0;
      e_cause = 0;
    end else if (m_redirect) begin
      e_redir = 1; e_nd = 1;
      e_fetch = {i_cop0_ivtbase, 10'b0} + 32'(vector_offset(m_last));
      e_cause = 3'(m_last);
      m_cause_ex = 0; m_cause_mem = 0;
      if (!stall) m_redirect = 0;
    end else begin
      if (m_cause_mem != 0)                        eff = m_cause_mem;
      else if (i_bus_err_p3)                       eff = 6;
      else if (i_intr && i_cop0_ie && i_valid_p3)  eff = 1;
      else                                         eff = 0;
      e_cause = 3'(m_last);
      if (eff != 0 && !stall) begin
        e_start = 1; e_nd = 1; e_nx = 1; e_nm = 1; e_nw = 1;
        e_dly = i_bdslot_p3;
        e_raddr = i_pc_p3;
        e_raddr_dly = i_pc_p3 + 32'hFFFF_FFFC;
        e_cause = 3'(eff);
        m_last = eff; m_redirect = 1; m_cause_ex = 0; m_cause_mem = 0;
      end else if (!stall) begin
        p1 = i_dec_err_p1 ? 2 : i_syscall_p1 ? 3 : i_break_p1 ? 4 : 0;
        m_cause_mem = (m_cause_ex != 0) ? m_cause_ex : (i_ovf_p2 ? 5 : 0);
        m_cause_ex  = p1;
      end
    end
    chk("start",     32'(o_except_start),    32'(e_start));
    chk("dly_slt",   32'(o_except_dly_slt),  32'(e_dly));
    chk("raddr",     o_except_raddr,         e_raddr);
    chk("raddr_dly", o_except_raddr_dly,     e_raddr_dly);
    chk("null_dec",  32'(o_nullify_decode),  32'(e_nd));
    chk("null_ex",   32'(o_nullify_execute), 32'(e_nx));
    chk("null_mem",  32'(o_nullify_mem),     32'(e_nm));
    chk("null_wb",   32'(o_nullify_wb),      32'(e_nw));
    chk("redirect",  32'(o_fetch_redirect),  32'(e_redir));
    chk("fetch",     o_fetch_addr,           e_fetch);
    chk("cause",     32'(o_except_cause),    32'(e_cause));
  endtask

  // Inputs are already set (just after a posedge); sample at the negedge, then move past the next posedge.
  task automatic applyStimulus();
    @(negedge clk);
    s_start = o_except_start; s_dly = o_except_dly_slt; s_redirect = o_fetch_redirect;
    s_null_wb = o_nullify_wb; s_raddr = o_except_raddr; s_raddr_dly = o_except_raddr_dly;
    s_fetch = o_fetch_addr; s_cause = o_except_cause;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 0;
    i_cop0_ivtbase = 22'h3;
    idle_inputs();
    i_bus_err_p3 = 1;
    applyStimulus();
    chk("rst_start", 32'(s_start), 32'd0);
    chk("rst_cause", 32'(s_cause), 32'd0);
    i_bus_err_p3 = 0;
    applyStimulus();
    nrst = 1;

    // Decode error travels two stages before entry.
    i_dec_err_p1 = 1;
    applyStimulus();
    i_dec_err_p1 = 0;
    applyStimulus();
    chk("s1_no_early", 32'(s_start), 32'd0);
    i_pc_p3 = 32'h100;
    applyStimulus();
    chk("s1_start", 32'(s_start), 32'd1);
    chk("s1_raddr", s_raddr, 32'h100);
    chk("s1_cause", 32'(s_cause), 32'd2);
    i_pc_p3 = 32'h0;
    applyStimulus();
    chk("s1_redir", 32'(s_redirect), 32'd1);
`ifdef CPU_EXC_VECTORED_EN
    chk("s1_fetch", s_fetch, 32'hD00);
`else
    chk("s1_fetch", s_fetch, 32'hC00);
`endif

    // Bus error on a delay-slot instruction.
    i_bus_err_p3 = 1; i_bdslot_p3 = 1; i_pc_p3 = 32'h204;
    applyStimulus();
    chk("s2_dly", 32'(s_dly), 32'd1);
    chk("s2_raddr_dly", s_raddr_dly, 32'h200);
    chk("s2_cause", 32'(s_cause), 32'd6);
    chk("s2_null_wb", 32'(s_null_wb), 32'd1);
    idle_inputs();
    applyStimulus();

    // Interrupt masked, then enabled.
    i_intr = 1; i_cop0_ie = 0;
    applyStimulus();
    chk("s3_masked", 32'(s_start), 32'd0);
    applyStimulus();
    chk("s3_masked2", 32'(s_start), 32'd0);
    i_cop0_ie = 1;
    applyStimulus();
    chk("s3_start", 32'(s_start), 32'd1);
    chk("s3_cause", 32'(s_cause), 32'd1);
    idle_inputs();
    applyStimulus();

    // Older bus error beats younger overflow; overflow is flushed.
    i_ovf_p2 = 1; i_bus_err_p3 = 1;
    applyStimulus();
    chk("s4_cause", 32'(s_cause), 32'd6);
    idle_inputs();
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      chk("s4_flushed", 32'(s_start), 32'd0);
    end

    // Memory stall holds the trigger, then fetch stall stretches REDIR.
    i_bus_err_p3 = 1; i_mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      chk("s5_stalled", 32'(s_start), 32'd0);
    end
    i_mem_stall = 0;
    applyStimulus();
    chk("s5_start", 32'(s_start), 32'd1);
    i_bus_err_p3 = 0; i_fetch_stall = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      chk("s5_hold", 32'(s_redirect), 32'd1);
      chk("s5_once", 32'(s_start), 32'd0);
    end
    i_fetch_stall = 0;
    applyStimulus();
    chk("s5_last", 32'(s_redirect), 32'd1);
    applyStimulus();
    chk("s5_done", 32'(s_redirect), 32'd0);

    // Reset during REDIR aborts the redirect.
    i_bus_err_p3 = 1;
    applyStimulus();
    i_bus_err_p3 = 0;
    nrst = 0;
    applyStimulus();
    chk("s6_redir", 32'(s_redirect), 32'd0);
    chk("s6_fetch", s_fetch, 32'd0);
    chk("s6_cause", 32'(s_cause), 32'd0);
    nrst = 1;
    applyStimulus();
    chk("s6_after", 32'(s_redirect), 32'd0);

    // Randomized traffic checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      nrst          = ($urandom_range(0, 399) != 0);
      i_exec_stall  = ($urandom_range(0, 9) == 0);
      i_mem_stall   = ($urandom_range(0, 9) == 0);
      i_fetch_stall = ($urandom_range(0, 9) == 0);
      i_cop0_ie     = ($urandom_range(0, 3) != 0);
      i_intr        = ($urandom_range(0, 5) == 0);
      i_dec_err_p1  = ($urandom_range(0, 15) == 0);
      i_syscall_p1  = ($urandom_range(0, 15) == 0);
      i_break_p1    = ($urandom_range(0, 15) == 0);
      i_ovf_p2      = ($urandom_range(0, 15) == 0);
      i_bus_err_p3  = ($urandom_range(0, 19) == 0);
      i_valid_p3    = ($urandom_range(0, 3) != 0);
      i_bdslot_p3   = ($urandom_range(0, 3) == 0);
      i_pc_p3       = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) i_cop0_ivtbase = 22'($urandom);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
